ctrlunit_multi: RTL and testbench

//   Parametrised multi-operand control unit for the compare/load micro datapath.

---
 rtl/ctrlunit_multi_if.sv | 46 ++++
 rtl/ctrlunit_multi.sv | 122 ++++++++++++
 tb/tb_ctrlunit_multi.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrlunit_multi_if.sv
// +--------------------------------------------------------------------+
// | Module  : ctrlunit_multi_if                                        |
// | Brief   : Handshake/control bundle for ctrlunit_multi.             |
// |           The abort signal exists only when CTRL_ABORT_EN is set.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface ctrlunit_multi_if #(
  parameter int N_OPS = 4
);
  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int CNT_W = $clog2(N_OPS + 1);

  logic             start;
  logic             Astatus;
`ifdef CTRL_ABORT_EN
  logic             abort;
`endif
  logic             ALoad;
  logic             BLoad;
  logic             Muxsel;
  logic             out_ctrl;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] op_idx;
  logic [CNT_W-1:0] eq_count;

  modport master (
`ifdef CTRL_ABORT_EN
    output abort,
`endif
    output start, Astatus,
    input  ALoad, BLoad, Muxsel, out_ctrl, busy, done, op_idx, eq_count
  );

  modport slave (
`ifdef CTRL_ABORT_EN
    input  abort,
`endif
    input  start, Astatus,
    output ALoad, BLoad, Muxsel, out_ctrl, busy, done, op_idx, eq_count
  );
endinterface

`default_nettype wire

// File: rtl/ctrlunit_multi.sv
// +--------------------------------------------------------------------+
// | Module  : ctrlunit_multi                                           |
// | Brief   : Multi-operand compare/load control FSM with start/done   |
// |           handshake. Optional abort input under CTRL_ABORT_EN.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ctrlunit_multi #(
  parameter int N_OPS    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic             clock,
  input  logic             rst,
  ctrlunit_multi_if.slave  ctl
);

  localparam int IDX_W  = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int CNT_W  = $clog2(N_OPS + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N_OPS - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INPUT    = 3'd1,
    S_EXTRA    = 3'd2,
    S_EQUAL    = 3'd3,
    S_NOTEQUAL = 3'd4,
    S_OUTPUT   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_op_idx;
  logic [IDX_W-1:0]    w_op_idx_nxt;
  logic [CNT_W-1:0]    r_eq_count;
  logic [CNT_W-1:0]    w_eq_count_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_abort;

`ifdef CTRL_ABORT_EN
  assign w_abort = ctl.abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_idx   <= '0;
      r_eq_count <= '0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_idx   <= w_op_idx_nxt;
      r_eq_count <= w_eq_count_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_idx_nxt   = r_op_idx;
    w_eq_count_nxt = r_eq_count;
    w_hold_nxt     = r_hold;
    case (r_state)
      S_IDLE: begin
        if (ctl.start) begin
          w_state_nxt    = S_INPUT;
          w_op_idx_nxt   = '0;
          w_eq_count_nxt = '0;
        end
      end
      S_INPUT: w_state_nxt = S_EXTRA;
      S_EXTRA: w_state_nxt = ctl.Astatus ? S_EQUAL : S_NOTEQUAL;
      S_EQUAL, S_NOTEQUAL: begin
        if (r_state == S_EQUAL) begin
          w_eq_count_nxt = r_eq_count + CNT_W'(1);
        end
        if (r_op_idx == c_last_idx) begin
          w_state_nxt = S_OUTPUT;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt  = S_INPUT;
          w_op_idx_nxt = r_op_idx + IDX_W'(1);
        end
      end
      S_OUTPUT: begin
        if (r_hold == c_hold_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // An aborted job freezes its counters so the partial result stays visible.
    if (w_abort) begin
      w_state_nxt    = S_IDLE;
      w_op_idx_nxt   = r_op_idx;
      w_eq_count_nxt = r_eq_count;
      w_hold_nxt     = r_hold;
    end
  end

  assign ctl.ALoad    = (r_state == S_INPUT);
  assign ctl.BLoad    = (r_state == S_EQUAL) || (r_state == S_NOTEQUAL);
  assign ctl.Muxsel   = (r_state == S_EQUAL);
  assign ctl.out_ctrl = (r_state == S_OUTPUT);
  assign ctl.done     = (r_state == S_DONE);
  assign ctl.busy     = (r_state != S_IDLE);
  assign ctl.op_idx   = r_op_idx;
  assign ctl.eq_count = r_eq_count;

endmodule

`default_nettype wire

// File: tb/tb_ctrlunit_multi.sv
// +--------------------------------------------------------------------+
// | Module  : tb_ctrlunit_multi                                        |
// | Brief   : Self-checking bench for ctrlunit_multi (4/2 and 1/1       |
// |           configurations); abort scenario under CTRL_ABORT_EN.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ctrlunit_multi;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic start_v  = 1'b0;
  logic astat_v  = 1'b0;
  int   sel      = 0;
`ifdef CTRL_ABORT_EN
  logic abort_v  = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;
  int m_idx [2];
  int m_eq  [2];

  always #5 clock = ~clock;

  ctrlunit_multi_if #(.N_OPS(4)) bus0 ();
  ctrlunit_multi_if #(.N_OPS(1)) bus1 ();

  assign bus0.start   = (sel == 0) && start_v;
  assign bus1.start   = (sel == 1) && start_v;
  assign bus0.Astatus = astat_v;
  assign bus1.Astatus = astat_v;
`ifdef CTRL_ABORT_EN
  assign bus0.abort   = abort_v;
  assign bus1.abort   = 1'b0;
`endif

  ctrlunit_multi #(.N_OPS(4), .HOLD_CYC(2)) dut0 (.clock(clock), .rst(rst), .ctl(bus0));
  ctrlunit_multi #(.N_OPS(1), .HOLD_CYC(1)) dut1 (.clock(clock), .rst(rst), .ctl(bus1));

  // {ALoad,BLoad,Muxsel,out_ctrl,busy,done,op_idx[3:0],eq_count[3:0]}
  logic [13:0] obs0, obs1;
  always_comb begin
    obs0 = {bus0.ALoad, bus0.BLoad, bus0.Muxsel, bus0.out_ctrl, bus0.busy, bus0.done,
            4'(bus0.op_idx), 4'(bus0.eq_count)};
    obs1 = {bus1.ALoad, bus1.BLoad, bus1.Muxsel, bus1.out_ctrl, bus1.busy, bus1.done,
            4'(bus1.op_idx), 4'(bus1.eq_count)};
  end

  function automatic int popcnt(input logic [7:0] a, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(a[i]);
    return c;
  endfunction

  // Cycle k after the accepted start: 3 cycles per operand, then hold, then done.
  function automatic logic [13:0] exp_vec(input int n, input int h, input logic [7:0] a, input int k);
    int j, ph, idx, eqc;
    logic al, bl, mx, oc, dn;
    al = 0; bl = 0; mx = 0; oc = 0; dn = 0;
    if (k <= 3 * n) begin
      j   = (k - 1) / 3;
      ph  = (k - 1) % 3;
      idx = j;
      eqc = popcnt(a, j);
      al  = (ph == 0);
      bl  = (ph == 2);
      mx  = (ph == 2) && a[j];
    end else begin
      idx = n - 1;
      eqc = popcnt(a, n);
      oc  = (k <= 3 * n + h);
      dn  = (k == 3 * n + h + 1);
    end
    return {al, bl, mx, oc, 1'b1, dn, 4'(idx), 4'(eqc)};
  endfunction

  function automatic logic [13:0] idle_vec(input int s);
    return {6'b0, 4'(m_idx[s]), 4'(m_eq[s])};
  endfunction

  task automatic check_idle(input int s, input string tag);
    logic [13:0] o;
    o = (s == 1) ? obs1 : obs0;
    nvec++;
    if (o !== idle_vec(s)) begin
      nerr++;
      $display("FAIL %s dut%0d: got %b expected %b", tag, s, o, idle_vec(s));
    end
  endtask

  // stop_kind: 0 none, 1 reset at cycle stop_k, 2 abort at cycle stop_k
  task automatic run_job(input int s, input logic [7:0] a, input bit keep_start,
                         input int stop_k, input int stop_kind);
    int n, h, len;
    bit stopped;
    logic [13:0] e, o;
    n = (s == 1) ? 1 : 4;
    h = (s == 1) ? 1 : 2;
    len = 3 * n + h + 1;
    stopped = 0;
    sel = s;
    start_v = 1'b1;
    astat_v = 1'($urandom);
    for (int k = 1; k <= len; k++) begin
      @(posedge clock); @(negedge clock);
      e = exp_vec(n, h, a, k);
      o = (s == 1) ? obs1 : obs0;
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL job dut%0d a=%b cycle %0d: got %b expected %b", s, a, k, o, e);
      end
      if (k == stop_k) begin
        start_v = 1'b0;
        if (stop_kind == 1) begin
          rst = 1'b1;
          m_idx[0] = 0; m_eq[0] = 0; m_idx[1] = 0; m_eq[1] = 0;
        end else begin
`ifdef CTRL_ABORT_EN
          abort_v = 1'b1;
`endif
          m_idx[s] = int'(e[7:4]);
          m_eq[s]  = int'(e[3:0]);
        end
        stopped = 1;
        break;
      end
      astat_v = (k <= 3 * n && (k - 1) % 3 == 1) ? a[(k - 1) / 3] : 1'($urandom);
      start_v = keep_start ? 1'b1 : ((k == len) ? 1'b0 : 1'($urandom));
    end
    if (!stopped) begin
      m_idx[s] = n - 1;
      m_eq[s]  = popcnt(a, n);
    end
    @(posedge clock); @(negedge clock);
    check_idle(s, stopped ? "after_stop" : "after_done");
    if (stopped) begin
      rst = 1'b0;
`ifdef CTRL_ABORT_EN
      abort_v = 1'b0;
`endif
      @(posedge clock); @(negedge clock);
      check_idle(s, "stop_settle");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v = 1'($urandom);
      astat_v = 1'($urandom);
      @(posedge clock);
    end
    @(negedge clock);
    m_idx[0] = 0; m_eq[0] = 0; m_idx[1] = 0; m_eq[1] = 0;
    check_idle(0, "reset");
    check_idle(1, "reset");
    start_v = 1'b0;
    rst = 1'b0;
    @(posedge clock); @(negedge clock);
    check_idle(0, "post_reset");
  endtask

  task automatic test_spec_pattern();
    run_job(0, 8'b0000_1101, 1'b0, 0, 0);
  endtask

  task automatic test_all_notequal();
    run_job(0, 8'b0000_0000, 1'b0, 0, 0);
  endtask

  task automatic test_random_jobs();
    for (int i = 0; i < 6; i++) run_job(0, 8'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_job(0, 8'($urandom), 1'b1, 0, 0);
    run_job(0, 8'($urandom), 1'b1, 0, 0);
    run_job(0, 8'b0000_1111, 1'b0, 0, 0);
  endtask

  task automatic test_reset_midjob();
    run_job(0, 8'b0000_0111, 1'b0, 8, 1);
  endtask

  task automatic test_single_op();
    run_job(1, 8'b0000_0001, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) run_job(1, 8'($urandom), 1'b0, 0, 0);
    run_job(1, 8'b0000_0000, 1'b0, 0, 0);
  endtask

`ifdef CTRL_ABORT_EN
  task automatic test_abort();
    run_job(0, 8'b0000_1011, 1'b0, 13, 2);
    run_job(0, 8'b0000_0110, 1'b0, 5, 2);
    run_job(0, 8'($urandom), 1'b0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_spec_pattern();
    test_all_notequal();
    test_random_jobs();
    test_back_to_back();
    test_reset_midjob();
    test_single_op();
`ifdef CTRL_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
